// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: owner-state enum, lsu_op size codes, byte-enable constants,
// RAM command struct and the "access behaves as a word" helper.
// Optional build macro: DMEM_ARB_DBG_PORT_EN adds the RD_DBG owner state.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_LSU = 2'd1,
    ST_RD_IF  = 2'd2
`ifdef DMEM_ARB_DBG_PORT_EN
    , ST_RD_DBG = 2'd3
`endif
  } owner_e;

  // funct3 load/store size codes; bit 2 selects zero-extension on loads
  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_cmd_t;

  // Word accesses, the unused size code 3 and misaligned halves are all
  // carried out as a full word at the aligned address.
  function automatic logic lsu_is_word(input logic [2:0] op, input logic [1:0] off);
    return (op[1:0] == SZ_WORD) || (op[1:0] == 2'd3) ||
           ((op[1:0] == SZ_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/dmem_ldalign.sv
// Load-data alignment: picks the addressed byte/half out of a RAM word and
// sign- or zero-extends it. Latency: combinational. Backpressure: none.
// Ports: op (registered funct3), off (registered byte offset), rdata (RAM
// word) in; data (aligned, extended load value) out.
module dmem_ldalign
  import dmem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    // word accesses always arrive with off = 0, so sh equals rdata for them
    sh = rdata >> {off, 3'b000};
    case (op[1:0])
      SZ_BYTE: data = op[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: data = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/dmem_arb.sv
// Single-port data RAM arbiter between LSU and instruction fetch.
// Latency: grant and RAM command same cycle; read data/rvalid one cycle later.
// Backpressure: losing requester sees gnt=0 and must hold its request; LSU
// wins by default, fetch wins after LSU_MAX_RUN back-to-back LSU grants.
// Ports: clk, cpurst_n; lsu_* request/grant/load-return; if_* fetch
// request/grant/return; flush; ram_* RAM command and ram_rdata; mem_stall.
// Optional build macro: DMEM_ARB_DBG_PORT_EN adds a top-priority dbg_* word port.
module dmem_arb
  import dmem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int LSU_MAX_RUN = 4
) (
  input  logic          clk,
  input  logic          cpurst_n,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [31:0]   lsu_wdata,
  input  logic [2:0]    lsu_op,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [31:0]   lsu_rdata,
  output logic          mem_stall,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          flush,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
`ifdef DMEM_ARB_DBG_PORT_EN
  ,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata
`endif
);

  localparam int RW = (LSU_MAX_RUN < 1) ? 1 : $clog2(LSU_MAX_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LSU_MAX_RUN);

  owner_e        state;
  logic [RW-1:0] run;
  logic [2:0]    ld_op;
  logic [1:0]    ld_off;
  logic          dbg_win, lsu_win, if_win;
  logic          lsu_word;
  logic [2:0]    lsu_op_eff;
  logic [1:0]    lsu_off_eff;
  ram_cmd_t      cmd;
  logic [31:0]   ld_data;

`ifdef DMEM_ARB_DBG_PORT_EN
  assign dbg_win = cpurst_n & dbg_req;
`else
  assign dbg_win = 1'b0;
`endif

  // Fetch is blocked during flush; a starved fetch overrides the LSU.
  assign if_win  = cpurst_n & ~dbg_win & if_req & ~flush &
                   (~lsu_req | (run == RUN_MAX));
  assign lsu_win = cpurst_n & ~dbg_win & lsu_req & ~if_win;

  assign lsu_word    = lsu_is_word(lsu_op, lsu_addr[1:0]);
  assign lsu_op_eff  = lsu_word ? OP_LW : lsu_op;
  assign lsu_off_eff = lsu_word ? 2'b00 : lsu_addr[1:0];

  always_comb begin
    cmd      = '0;
    ram_addr = '0;
`ifdef DMEM_ARB_DBG_PORT_EN
    if (dbg_win) begin
      cmd.en    = 1'b1;
      cmd.we    = dbg_we;
      cmd.be    = BE_WORD;
      cmd.wdata = dbg_we ? dbg_wdata : 32'h0;
      ram_addr  = dbg_addr & ~AW'(3);
    end else
`endif
    if (lsu_win) begin
      cmd.en   = 1'b1;
      cmd.we   = lsu_we;
      ram_addr = lsu_addr & ~AW'(3);
      if (lsu_word)
        cmd.be = BE_WORD;
      else if (lsu_op[1:0] == SZ_BYTE)
        cmd.be = BE_BYTE << lsu_addr[1:0];
      else
        cmd.be = BE_HALF << {lsu_addr[1], 1'b0};
      // sub-word stores are replicated so every lane carries the data
      if (lsu_we) begin
        if (lsu_word)
          cmd.wdata = lsu_wdata;
        else if (lsu_op[1:0] == SZ_BYTE)
          cmd.wdata = {4{lsu_wdata[7:0]}};
        else
          cmd.wdata = {2{lsu_wdata[15:0]}};
      end
    end else if (if_win) begin
      cmd.en   = 1'b1;
      cmd.be   = BE_WORD;
      ram_addr = if_addr;
    end
  end

  assign ram_en    = cmd.en;
  assign ram_we    = cmd.we;
  assign ram_be    = cmd.be;
  assign ram_wdata = cmd.wdata;

  // Owner of the read data returning next cycle, starvation counter and
  // the load size/offset needed to align that data.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state  <= ST_IDLE;
      run    <= '0;
      ld_op  <= '0;
      ld_off <= '0;
    end else begin
      if (lsu_win && !lsu_we)
        state <= ST_RD_LSU;
      else if (if_win)
        state <= ST_RD_IF;
`ifdef DMEM_ARB_DBG_PORT_EN
      else if (dbg_win && !dbg_we)
        state <= ST_RD_DBG;
`endif
      else
        state <= ST_IDLE;

      if (if_win || !if_req)
        run <= '0;
      else if (lsu_win && (run != RUN_MAX))
        run <= run + RW'(1);

      if (lsu_win && !lsu_we) begin
        ld_op  <= lsu_op_eff;
        ld_off <= lsu_off_eff;
      end
    end
  end

  dmem_ldalign u_ldalign (
    .op    (ld_op),
    .off   (ld_off),
    .rdata (ram_rdata),
    .data  (ld_data)
  );

  assign lsu_gnt    = lsu_win;
  assign if_gnt     = if_win;
  assign lsu_rvalid = (state == ST_RD_LSU);
  assign lsu_rdata  = lsu_rvalid ? ld_data : 32'h0;
  // A flush kills the fetch data returning in the same cycle.
  assign if_rvalid  = (state == ST_RD_IF) & ~flush;
  assign if_rdata   = if_rvalid ? ram_rdata : 32'h0;
  // Load data always returns the very next cycle, so only an ungranted
  // request holds the pipeline.
  assign mem_stall  = lsu_req & ~lsu_win;

`ifdef DMEM_ARB_DBG_PORT_EN
  assign dbg_gnt    = dbg_win;
  assign dbg_rvalid = (state == ST_RD_DBG);
  assign dbg_rdata  = dbg_rvalid ? ram_rdata : 32'h0;
`endif

endmodule

// File: tb/tb_dmem_arb.sv
module tb_dmem_arb;

  localparam int AW   = 32;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          cpurst_n = 1'b0;
  logic          lsu_req = 1'b0, lsu_we = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [31:0]   lsu_wdata = '0;
  logic [2:0]    lsu_op = '0;
  logic          lsu_gnt, lsu_rvalid, mem_stall;
  logic [31:0]   lsu_rdata;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          flush = 1'b0;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  dmem_arb #(.AW(AW), .LSU_MAX_RUN(MAXR)) dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_op(lsu_op),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_stall(mem_stall),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .flush(flush),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: consecutive LSU wins while fetch waits, and
  // which read (0 none, 1 LSU load, 2 fetch) returns next cycle
  int          m_run = 0;
  int          m_pend = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (op % 4 == 0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (op < 4 && v >= 128) v = v - 256;
    end else if (op % 4 == 1 && off % 2 == 0) begin
      v = (rd >> (8 * off)) & 32'hFFFF;
      if (op < 4 && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (op % 4 == 0) return 4'(1 << off);
    if (op % 4 == 1 && off % 2 == 0) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] wd);
    if (op % 4 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (op % 4 == 1 && addr % 2 == 0) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic settle();
    #3;
  endtask

  // compare all outputs against the model for the inputs applied this
  // cycle, advance the model, then move to just after the next rising edge
  task automatic tick();
    logic fw, e_lg, e_ig;
    if (!cpurst_n) begin
      check("rst_lsu_gnt", lsu_gnt, 1'b0);
      check("rst_if_gnt", if_gnt, 1'b0);
      check("rst_ram_en", ram_en, 1'b0);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_lsu_rvalid", lsu_rvalid, 1'b0);
      check("rst_if_rvalid", if_rvalid, 1'b0);
      check("rst_lsu_rdata", lsu_rdata, 32'h0);
      m_run  = 0;
      m_pend = 0;
    end else begin
      fw   = if_req && !flush && (!lsu_req || m_run == MAXR);
      e_ig = fw;
      e_lg = lsu_req && !fw;
      check("lsu_gnt", lsu_gnt, e_lg);
      check("if_gnt", if_gnt, e_ig);
      check("mem_stall", mem_stall, lsu_req && !e_lg);
      check("lsu_rvalid", lsu_rvalid, m_pend == 1);
      if (m_pend == 1) check("lsu_rdata", lsu_rdata, load_value(m_op, m_addr, ram_rdata));
      check("if_rvalid", if_rvalid, (m_pend == 2) && !flush);
      if (m_pend == 2 && !flush) check("if_rdata", if_rdata, ram_rdata);
      check("ram_en", ram_en, e_lg || e_ig);
      if (e_lg) begin
        check("ram_we", ram_we, lsu_we);
        check("ram_addr", ram_addr, lsu_addr & ~32'd3);
        check("ram_be", ram_be, exp_be(lsu_op, lsu_addr));
        if (lsu_we) check("ram_wdata", ram_wdata, exp_wdata(lsu_op, lsu_addr, lsu_wdata));
      end else if (e_ig) begin
        check("ram_we_if", ram_we, 1'b0);
        check("ram_addr_if", ram_addr, if_addr);
      end else begin
        check("idle_ram_we", ram_we, 1'b0);
        check("idle_ram_be", ram_be, 4'h0);
        check("idle_ram_addr", ram_addr, 32'h0);
        check("idle_ram_wdata", ram_wdata, 32'h0);
      end
      if (e_ig || !if_req) m_run = 0;
      else if (e_lg && m_run < MAXR) m_run++;
      if (e_lg && !lsu_we) begin
        m_pend = 1;
        m_op   = lsu_op;
        m_addr = lsu_addr;
      end else if (e_ig) begin
        m_pend = 2;
      end else begin
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    // reset held with both requesters active
    cpurst_n = 1'b0; lsu_req = 1'b1; if_req = 1'b1; lsu_op = 3'd2; lsu_addr = 32'h40;
    settle(); tick();
    settle(); tick();

    // continuous loads while fetch waits: LSU wins four times, then fetch
    cpurst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = 3'd2; lsu_addr = 32'h40 + 4 * k;
      if_req = 1'b1; if_addr = 32'h1000; ram_rdata = $urandom;
      settle();
      if (k == 1) begin
        check("same_cycle_lsu_gnt", lsu_gnt, 1'b1);
        check("same_cycle_if_gnt", if_gnt, 1'b0);
        check("same_cycle_stall", mem_stall, 1'b0);
      end
      if (k == 4) check("run4_lsu_gnt", lsu_gnt, 1'b1);
      if (k == 5) begin
        check("run5_if_gnt", if_gnt, 1'b1);
        check("run5_lsu_gnt", lsu_gnt, 1'b0);
        check("run5_stall", mem_stall, 1'b1);
      end
      tick();
    end
    lsu_req = 1'b0; if_req = 1'b0; ram_rdata = $urandom;
    settle(); tick();

    // SB to 0x103
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_op = 3'd0; lsu_addr = 32'h103; lsu_wdata = 32'h000000AB;
    settle();
    check("sb_be", ram_be, 4'b1000);
    check("sb_wdata", ram_wdata, 32'hABABABAB);
    check("sb_we", ram_we, 1'b1);
    tick();
    lsu_req = 1'b0; lsu_we = 1'b0; ram_rdata = 32'h55555555;
    settle();
    check("sb_no_rvalid", lsu_rvalid, 1'b0);
    tick();

    // LH / LHU from 0x102
    lsu_req = 1'b1; lsu_op = 3'd1; lsu_addr = 32'h102;
    settle(); tick();
    lsu_req = 1'b0; ram_rdata = 32'h80011234;
    settle();
    check("lh_rvalid", lsu_rvalid, 1'b1);
    check("lh_rdata", lsu_rdata, 32'hFFFF8001);
    tick();
    lsu_req = 1'b1; lsu_op = 3'd5; lsu_addr = 32'h102;
    settle(); tick();
    lsu_req = 1'b0; ram_rdata = 32'h80011234;
    settle();
    check("lhu_rvalid", lsu_rvalid, 1'b1);
    check("lhu_rdata", lsu_rdata, 32'h00008001);
    tick();

    // fetch granted, flush arrives while its data returns
    if_req = 1'b1; if_addr = 32'h200;
    settle(); tick();
    flush = 1'b1; ram_rdata = 32'hDEADBEEF;
    settle();
    check("flush_if_rvalid", if_rvalid, 1'b0);
    check("flush_if_gnt", if_gnt, 1'b0);
    tick();
    flush = 1'b0; if_req = 1'b0;
    settle(); tick();

    // reset asserted while a load is in flight
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = 3'd2; lsu_addr = 32'h300;
    settle(); tick();
    cpurst_n = 1'b0; lsu_req = 1'b0; ram_rdata = 32'h12345678;
    settle();
    check("rst_mid_load_rvalid", lsu_rvalid, 1'b0);
    tick();
    cpurst_n = 1'b1; lsu_req = 1'b1; lsu_we = 1'b1; lsu_op = 3'd2; lsu_wdata = 32'hCAFEF00D;
    settle();
    check("post_rst_rvalid", lsu_rvalid, 1'b0);
    check("post_rst_gnt", lsu_gnt, 1'b1);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cpurst_n  = ($urandom % 97) != 0;
      lsu_req   = ($urandom % 3) != 0;
      lsu_we    = ($urandom % 3) == 0;
      lsu_op    = ops[$urandom % 5];
      lsu_addr  = $urandom;
      lsu_wdata = $urandom;
      if_req    = ($urandom % 4) != 0;
      if_addr   = $urandom & ~32'd3;
      flush     = ($urandom % 10) == 0;
      ram_rdata = $urandom;
      settle(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
